// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM encoding, idle/reset
// patterns and small bit helpers used by the scanner datapath.
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    ST_SCAN    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_HOLD    = 2'd2
  } scan_state_e;

  localparam logic [3:0] COL_RESET  = 4'b1110;
  localparam logic [3:0] ROWS_IDLE  = 4'b1111;
  localparam int         KEY_CODE_W = 4;

  // Index of the lowest-numbered low bit; callers only use it on non-idle inputs.
  function automatic logic [1:0] low_index(input logic [3:0] bits);
    logic [1:0] idx;
    idx = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (!bits[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] next_col(input logic [3:0] c);
    return {c[2:0], c[3]};
  endfunction

endpackage

// File: rtl/keypad_scanner_scan_tick.sv
// Free-running divider producing a one-clk tick every CLK_DIV clocks.
// Reusable wherever a slow periodic strobe is needed.
module scan_tick_gen #(
  parameter int CLK_DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [TW-1:0] cnt;

  assign tick = (cnt == TW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: strobes one column per tick, debounces
// press and release, and reports a single-cycle event with the key code.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int CLK_DIV      = 100000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            row,
  output logic [3:0]            col,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_valid,
  output logic                  key_held
);

  localparam int             CNT_W    = $clog2(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  logic             tick;
  logic [3:0]       row_p0;
  logic [3:0]       row_p1;
  logic [3:0]       srow;
  scan_state_e      state;
  logic [3:0]       pattern;
  logic [1:0]       row_idx;
  logic [1:0]       col_idx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] rel;

  scan_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // Stage p0/p1: two-flop synchroniser on the asynchronous row inputs
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      row_p0 <= ROWS_IDLE;
      row_p1 <= ROWS_IDLE;
    end else begin
      row_p0 <= row;
      row_p1 <= row_p0;
    end
  end

  assign srow = row_p1;

  // Scan/debounce FSM; acts only on tick cycles, key_valid self-clears
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= ST_SCAN;
      col       <= COL_RESET;
      pattern   <= ROWS_IDLE;
      row_idx   <= 2'd0;
      col_idx   <= 2'd0;
      cnt       <= '0;
      rel       <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        case (state)
          ST_SCAN: begin
            if (srow == ROWS_IDLE) begin
              col <= next_col(col);
            end else begin
              pattern <= srow;
              row_idx <= low_index(srow);
              col_idx <= low_index(col);
              cnt     <= CNT_W'(1);
              state   <= ST_CONFIRM;
            end
          end
          ST_CONFIRM: begin
            if (srow != pattern) begin
              col   <= next_col(col);
              state <= ST_SCAN;
            end else if (cnt == DEB_LAST) begin
              key_code  <= {row_idx, col_idx};
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              rel       <= '0;
              state     <= ST_HOLD;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_HOLD: begin
            // Any activity on the frozen column restarts the release count
            if (srow != ROWS_IDLE) begin
              rel <= '0;
            end else if (rel == DEB_LAST) begin
              key_held <= 1'b0;
              col      <= next_col(col);
              state    <= ST_SCAN;
            end else begin
              rel <= rel + 1'b1;
            end
          end
          default: begin
            state <= ST_SCAN;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix;
// CLK_DIV=4, DEBOUNCE_CNT=3, so one scan tick is exactly four clocks.
module tb_keypad_scanner;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed;

  int n_cmp  = 0;
  int n_fail = 0;
  int vcount = 0;
  int vbase;

  keypad_scanner #(
    .CLK_DIV     (4),
    .DEBOUNCE_CNT(3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key matrix: a pressed key pulls its row low while its column is strobed
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (key_valid === 1'b1) vcount = vcount + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h required %0h", tag, obs, exp);
      $error("%s mismatched", tag);
    end
  endtask

  // Advance one scan tick and land on the negedge just after the tick edge
  task automatic step();
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n   = 1'b1;
    pressed = 16'h0000;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_col",   col,       4'b1110);
    check("rst_code",  key_code,  4'h0);
    check("rst_valid", key_valid, 1'b0);
    check("rst_held",  key_held,  1'b0);
    rst_n = 1'b0;

    // Idle scan rotation
    step(); check("scan_c1", col, 4'b1101);
    step(); check("scan_c2", col, 4'b1011);
    step(); check("scan_c3", col, 4'b0111);
    step(); check("scan_c0", col, 4'b1110);
    check("scan_novalid", vcount, 0);

    // Steady press r1,c2
    vbase = vcount;
    pressed[6] = 1'b1;
    step(); check("p6_col1", col, 4'b1101);
    step(); check("p6_col2", col, 4'b1011);
    step(); check("p6_t0_valid", key_valid, 1'b0);
    step(); check("p6_t1_valid", key_valid, 1'b0);
    check("p6_t1_col", col, 4'b1011);
    step(); check("p6_valid", key_valid, 1'b1);
    check("p6_code", key_code, 4'd6);
    check("p6_held", key_held, 1'b1);
    step(); check("p6_pulse_end", key_valid, 1'b0);
    check("p6_frozen", col, 4'b1011);
    check("p6_count", vcount - vbase, 1);

    // Release bounce while holding
    vbase = vcount;
    pressed[6] = 1'b0;
    step(); check("rb_held1", key_held, 1'b1);
    step(); check("rb_held2", key_held, 1'b1);
    pressed[6] = 1'b1;
    step(); check("rb_held3", key_held, 1'b1);
    pressed[6] = 1'b0;
    step(); check("rb_held4", key_held, 1'b1);
    step(); check("rb_held5", key_held, 1'b1);
    step(); check("rb_drop", key_held, 1'b0);
    check("rb_col", col, 4'b0111);
    check("rb_novalid", vcount - vbase, 0);
    check("rb_code_kept", key_code, 4'd6);

    // Press bounce lasting one tick
    step(); step(); step();
    check("bn_col_pre", col, 4'b1011);
    pressed[6] = 1'b1;
    step(); check("bn_frozen", col, 4'b1011);
    pressed[6] = 1'b0;
    step(); check("bn_col_next", col, 4'b0111);
    check("bn_held", key_held, 1'b0);
    step(); check("bn_resume", col, 4'b1110);
    check("bn_novalid", vcount - vbase, 0);

    // Two rows in column 0: lowest row wins
    vbase = vcount;
    pressed[0] = 1'b1;
    pressed[8] = 1'b1;
    step(); step();
    step(); check("m_valid", key_valid, 1'b1);
    check("m_code", key_code, 4'd0);
    pressed[0] = 1'b0;
    pressed[8] = 1'b0;
    step(); step();
    step(); check("m_rel_held", key_held, 1'b0);
    check("m_rel_col", col, 4'b1101);
    check("m_count", vcount - vbase, 1);

    // Corner key r3,c3
    pressed[15] = 1'b1;
    step(); check("k15_col2", col, 4'b1011);
    step(); check("k15_col3", col, 4'b0111);
    step(); step();
    check("k15_early", key_valid, 1'b0);
    step(); check("k15_valid", key_valid, 1'b1);
    check("k15_code", key_code, 4'hF);
    pressed[15] = 1'b0;
    step(); step(); step();
    check("k15_rel_held", key_held, 1'b0);
    check("k15_rel_col", col, 4'b1110);

    // Reset during CONFIRM
    pressed[1] = 1'b1;
    step(); step(); step();
    check("rc_col_pre", col, 4'b1101);
    vbase = vcount;
    rst_n = 1'b1;
    #1;
    check("rc_col",   col,       4'b1110);
    check("rc_code",  key_code,  4'h0);
    check("rc_valid", key_valid, 1'b0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    step(); check("rc_scan", col, 4'b1101);
    step(); check("rc_t0", key_valid, 1'b0);
    step(); check("rc_t1", key_valid, 1'b0);
    step(); check("rc_valid_after", key_valid, 1'b1);
    check("rc_code_after", key_code, 4'd1);
    step(); check("rc_held", key_held, 1'b1);
    check("rc_count", vcount - vbase, 1);

    // Reset during HOLD
    vbase = vcount;
    rst_n = 1'b1;
    #1;
    check("rh_held", key_held, 1'b0);
    check("rh_col",  col,      4'b1110);
    check("rh_code", key_code, 4'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    step(); step(); step();
    check("rh_t1", key_valid, 1'b0);
    check("rh_none_yet", vcount - vbase, 0);
    step(); check("rh_valid", key_valid, 1'b1);
    check("rh_code_after", key_code, 4'd1);
    pressed[1] = 1'b0;
    step(); step(); step();
    check("rh_rel_held", key_held, 1'b0);
    check("rh_count", vcount - vbase, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Input-side counterpart to the multiplexed 7-segment display driver: scans a 4x4 active-low key matrix by strobing one column at a time and reading the rows. Filters contact bounce and emits a single-cycle key event with a 4-bit key code. Runs on the system clock with an internal scan tick. Feeds the start/stop/direction/digit-entry logic of the counter FSM in place of discrete pushbuttons.

Parameters:
CLK_DIV, 100000, clk cycles per scan tick (1 ms at 100 MHz); legal range >= 4
DEBOUNCE_CNT, 4, consecutive matching ticks required to accept a press and to accept a release; legal range >= 2

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-high (already decided)
row  input  4  matrix rows, active-low, externally pulled up
col  output  4  column strobes, active-low, exactly one bit low
key_code  output  4  row_idx*4 + col_idx of the last accepted key
key_valid  output  1  one-clk pulse on each accepted press
key_held  output  1  high while an accepted key remains pressed

Behaviour:
- Reset (asynchronous, on rst_n=1): col=4'b1110, key_code=0, key_valid=0, key_held=0, state SCAN, tick counter=0, debounce counter=0, row synchroniser=4'b1111. Reset mid-operation aborts any press or hold; no key_valid is emitted on release of reset.
- Row synchroniser: 2 flops on row; the FSM sees only synchronised rows (srow).
- Tick: counter 0..CLK_DIV-1; tick=1 for one clk when counter==CLK_DIV-1, then wraps to 0. All FSM decisions occur only on tick cycles. CLK_DIV>=4 guarantees srow settles after a column change.
- Row priority: lowest-index low bit of srow defines row_idx.
- SCAN: on tick, if srow==4'b1111, rotate col 1110->1101->1011->0111->1110. Otherwise latch srow into pattern, latch row_idx/col_idx, set cnt=1, go to CONFIRM. col is frozen.
- CONFIRM: on tick, if srow==pattern, cnt+1. When cnt+1==DEBOUNCE_CNT: key_code<=row_idx*4+col_idx, key_valid=1 for the next clk only, key_held<=1, rel=0, go to HOLD. On tick with srow!=pattern: go to SCAN and advance col one step (a bounce produces no event).
- HOLD: col stays frozen. On tick, if srow==4'b1111, rel+1; otherwise rel=0. When rel+1==DEBOUNCE_CNT: key_held<=0, go to SCAN, advance col. No new key_valid while in HOLD, including when a second key in the same column is pressed.
- key_code holds its value until the next accepted press and is never cleared by release.
- Latency: a steady press first seen on tick T produces key_valid one clk after tick T+(DEBOUNCE_CNT-1) ticks.
- Keys in other columns pressed during HOLD are ignored (the column is not strobed).

Decomposition:
- Shared package: state encoding (SCAN, CONFIRM, HOLD), COL_RESET=4'b1110, ROWS_IDLE=4'b1111, and the key-code width constant.
- One sub-module, scan_tick_gen (parameter CLK_DIV; ports clk, rst_n, tick). It is a reusable replacement for the ad-hoc dividers.

Test Plan:
All tests use CLK_DIV=4 and DEBOUNCE_CNT=3.
1. Reset, row=4'b1111 -> col=1110 with all outputs 0; col then steps 1101,1011,0111,1110 every 4 clk; key_valid never asserts.
2. row=4'b1101 whenever col=1011 (key r1,c2), held -> exactly one key_valid pulse with key_code=6; key_held=1; col frozen at 1011.
3. Press visible for 1 tick then row=4'b1111 -> no key_valid; next col is 0111 and scanning resumes.
4. From HOLD: release for 2 ticks, then low again, then release for 3 ticks -> key_held stays 1 through the bounce and drops after the 3rd idle tick; no second key_valid; scan resumes at 0111.
5. row=4'b1010 at col=1110 (rows 0 and 2) -> key_code=0; later r3,c3 -> key_code=15.
6. rst_n pulsed during CONFIRM and again during HOLD -> outputs are at reset values immediately; after deassertion, a full 3-tick debounce is required before key_valid.
